// File: rtl/jk_toggle_monitor.sv
// Observation stage behind a JK flip-flop: synchronises the q/q_n rails, detects q edges,
// counts toggles, times complete high phases and latches a rail-complementarity fault.
module jk_toggle_monitor #(
  parameter int CNT_W        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int FAULT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             q_in,
  input  logic             q_n_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] high_time,
  output logic             cnt_sat,
  output logic             fault,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       FAULT_LIM = 4'(FAULT_CYCLES);
  localparam logic [2:0]       PRIME_LIM = 3'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] q_sync_q, qn_sync_q;
  logic                   q_s, qn_s, q_d_q;
  logic [2:0]             prime_q, prime_d;
  logic                   primed;
  logic [3:0]             mm_q, mm_d;
  logic                   fault_hit;
  state_e                 state_q, state_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0]       toggle_q, toggle_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic                   hi_valid_q, hi_valid_d;
  logic                   cnt_sat_q, cnt_sat_d;
  logic                   fault_q, fault_d;

  assign q_s  = q_sync_q[SYNC_STAGES-1];
  assign qn_s = qn_sync_q[SYNC_STAGES-1];

  // Both rails read 0 until the synchronisers have filled after reset; that
  // window must not be mistaken for a q == q_n fault.
  assign primed    = (prime_q == PRIME_LIM);
  assign prime_d   = primed ? prime_q : prime_q + 3'd1;
  assign fault_hit = (mm_q == FAULT_LIM);

  always_comb begin
    mm_d = 4'd0;
    if (!clr && primed && (q_s == qn_s)) begin
      mm_d = fault_hit ? mm_q : mm_q + 4'd1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    toggle_d    = toggle_q;
    high_time_d = high_time_q;
    hi_cnt_d    = hi_cnt_q;
    hi_valid_d  = hi_valid_q;
    cnt_sat_d   = cnt_sat_q;
    fault_d     = fault_q;

    if (clr) begin
      state_d     = ST_INIT;
      toggle_d    = '0;
      high_time_d = '0;
      hi_cnt_d    = '0;
      hi_valid_d  = 1'b0;
      cnt_sat_d   = 1'b0;
      fault_d     = 1'b0;
    end else begin
      if (state_q == ST_FAULT) begin
        state_d = ST_FAULT;
      end else if (fault_hit) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else if (!en) begin
        state_d = ST_INIT;
      end else begin
        case (state_q)
          ST_INIT: begin
            if (q_s != qn_s) begin
              state_d = q_s ? ST_HIGH : ST_LOW;
              if (q_s) begin
                hi_valid_d = 1'b0;
                hi_cnt_d   = '0;
              end
            end
          end
          ST_LOW: begin
            if (q_s && !q_d_q) begin
              state_d    = ST_HIGH;
              rise_d     = 1'b1;
              toggle_d   = (toggle_q == CNT_MAX) ? toggle_q : toggle_q + CNT_W'(1);
              // The cycle that reveals the rise is already the first high cycle.
              hi_cnt_d   = CNT_W'(1);
              hi_valid_d = 1'b1;
            end
          end
          ST_HIGH: begin
            if (!q_s && q_d_q) begin
              state_d  = ST_LOW;
              fall_d   = 1'b1;
              toggle_d = (toggle_q == CNT_MAX) ? toggle_q : toggle_q + CNT_W'(1);
              if (hi_valid_q) high_time_d = hi_cnt_q;
            end else if (q_s) begin
              hi_cnt_d = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
            end
          end
          default: state_d = state_q;
        endcase
      end
      cnt_sat_d = cnt_sat_q | (toggle_d == CNT_MAX) | (hi_cnt_d == CNT_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: there is no memory array here, so every flop, synchronisers included, takes the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sync_q    <= '0;
      qn_sync_q   <= '0;
      q_d_q       <= 1'b0;
      prime_q     <= 3'd0;
      mm_q        <= 4'd0;
      state_q     <= ST_INIT;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      toggle_q    <= '0;
      high_time_q <= '0;
      hi_cnt_q    <= '0;
      hi_valid_q  <= 1'b0;
      cnt_sat_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      q_sync_q    <= {q_sync_q[SYNC_STAGES-2:0], q_in};
      qn_sync_q   <= {qn_sync_q[SYNC_STAGES-2:0], q_n_in};
      q_d_q       <= q_s;
      prime_q     <= prime_d;
      mm_q        <= mm_d;
      state_q     <= state_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      toggle_q    <= toggle_d;
      high_time_q <= high_time_d;
      hi_cnt_q    <= hi_cnt_d;
      hi_valid_q  <= hi_valid_d;
      cnt_sat_q   <= cnt_sat_d;
      fault_q     <= fault_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign toggle_cnt = toggle_q;
  assign high_time  = high_time_q;
  assign cnt_sat    = cnt_sat_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_jk_toggle_monitor.sv
// Self-checking bench for jk_toggle_monitor: directed vector table, hand-written corner
// sequences and a randomized run compared against a queue-based behavioural model.
module tb_jk_toggle_monitor;

  localparam int CNT_W        = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int FAULT_CYCLES = 2;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, clr, q_in, q_n_in;
  logic             rise_pulse, fall_pulse, cnt_sat, fault;
  logic [CNT_W-1:0] toggle_cnt, high_time;
  logic [1:0]       state;

  always #5 clk = ~clk;

  jk_toggle_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .FAULT_CYCLES(FAULT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .q_in      (q_in),
    .q_n_in    (q_n_in),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_cnt(toggle_cnt),
    .high_time (high_time),
    .cnt_sat   (cnt_sat),
    .fault     (fault),
    .state     (state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output bundle: {state, rise, fall, sat, fault, toggle_cnt, high_time, pad}
  function automatic logic [31:0] pack(logic [1:0] st, logic r, logic f, logic s, logic ft,
                                       logic [7:0] tg, logic [7:0] h);
    return {2'b00, st, r, f, s, ft, tg, h, 8'h00};
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(state, rise_pulse, fall_pulse, cnt_sat, fault, 8'(toggle_cnt), 8'(high_time));
  endfunction

  // Behavioural model: rail history queues stand in for the synchronisers.
  bit mh_q[$], mh_qn[$];
  int m_since, m_mm, m_mode, m_tog, m_ht, m_hc, m_hv, m_sat, m_fault, m_rise, m_fall;

  function automatic logic [31:0] model_pack();
    return pack(2'(m_mode), 1'(m_rise), 1'(m_fall), 1'(m_sat), 1'(m_fault), 8'(m_tog), 8'(m_ht));
  endfunction

  task automatic model_reset();
    mh_q = {};
    mh_qn = {};
    for (int i = 0; i <= SYNC_STAGES; i++) begin
      mh_q.push_back(1'b0);
      mh_qn.push_back(1'b0);
    end
    m_since = 0; m_mm = 0; m_mode = 0; m_tog = 0; m_ht = 0; m_hc = 0;
    m_hv = 0; m_sat = 0; m_fault = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic model_step();
    int qs, qns, qd, hit;
    if (rst) begin
      model_reset();
      return;
    end
    qs  = mh_q[SYNC_STAGES-1];
    qns = mh_qn[SYNC_STAGES-1];
    qd  = mh_q[SYNC_STAGES];
    m_rise = 0;
    m_fall = 0;
    if (clr) begin
      m_mode = 0; m_tog = 0; m_ht = 0; m_hc = 0; m_hv = 0; m_sat = 0; m_fault = 0; m_mm = 0;
    end else begin
      hit = (m_mm == FAULT_CYCLES);
      if (m_since >= SYNC_STAGES && qs == qns) m_mm = (m_mm < FAULT_CYCLES) ? m_mm + 1 : m_mm;
      else m_mm = 0;
      if (m_mode == 3) begin
        m_mode = 3;
      end else if (hit) begin
        m_mode = 3;
        m_fault = 1;
      end else if (!en) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (qs != qns) begin
          m_mode = qs ? 2 : 1;
          if (qs) begin m_hv = 0; m_hc = 0; end
        end
      end else if (m_mode == 1) begin
        if (qs && !qd) begin
          m_mode = 2; m_rise = 1; m_hc = 1; m_hv = 1;
          m_tog = (m_tog < CMAX) ? m_tog + 1 : CMAX;
        end
      end else begin
        if (!qs && qd) begin
          m_mode = 1; m_fall = 1;
          m_tog = (m_tog < CMAX) ? m_tog + 1 : CMAX;
          if (m_hv) m_ht = m_hc;
        end else if (qs) begin
          m_hc = (m_hc < CMAX) ? m_hc + 1 : CMAX;
        end
      end
      if (m_tog == CMAX || m_hc == CMAX) m_sat = 1;
    end
    if (m_since < SYNC_STAGES) m_since++;
    mh_q.push_front(q_in);
    mh_qn.push_front(q_n_in);
    void'(mh_q.pop_back());
    void'(mh_qn.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_rails(input logic q, input logic qn);
    q_in   = q;
    q_n_in = qn;
  endtask

  typedef struct {
    logic        en, clr, q, qn;
    logic [31:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input int e, input int c, input int q, input int qn,
                         input int st, input int r, input int f, input int tg,
                         input int h, input int s, input int ft);
    vec_t v;
    v.en  = 1'(e);
    v.clr = 1'(c);
    v.q   = 1'(q);
    v.qn  = 1'(qn);
    v.exp = pack(2'(st), 1'(r), 1'(f), 1'(s), 1'(ft), 8'(tg), 8'(h));
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rq;
    int   seen;
    int   pflip;

    //        en clr q qn | st r f tog ht sat flt
    add_vec(1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0,   2, 1, 0, 1, 0, 0, 0);
    add_vec(1, 0, 1, 0,   2, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 1, 0,   2, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 0, 1,   2, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 0, 1,   2, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 0, 1,   1, 0, 1, 2, 5, 0, 0);
    add_vec(1, 0, 0, 1,   1, 0, 0, 2, 5, 0, 0);
    add_vec(1, 0, 1, 0,   1, 0, 0, 2, 5, 0, 0);
    add_vec(1, 0, 1, 0,   1, 0, 0, 2, 5, 0, 0);
    add_vec(1, 0, 1, 1,   2, 1, 0, 3, 5, 0, 0);
    add_vec(1, 0, 1, 1,   2, 0, 0, 3, 5, 0, 0);
    add_vec(1, 0, 1, 0,   2, 0, 0, 3, 5, 0, 0);
    add_vec(1, 0, 1, 0,   2, 0, 0, 3, 5, 0, 0);
    add_vec(1, 0, 1, 0,   3, 0, 0, 3, 5, 0, 1);
    add_vec(1, 0, 0, 1,   3, 0, 0, 3, 5, 0, 1);
    add_vec(1, 0, 0, 1,   3, 0, 0, 3, 5, 0, 1);
    add_vec(1, 0, 1, 0,   3, 0, 0, 3, 5, 0, 1);
    add_vec(1, 0, 1, 0,   3, 0, 0, 3, 5, 0, 1);
    add_vec(1, 0, 0, 1,   3, 0, 0, 3, 5, 0, 1);
    add_vec(1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);

    model_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    set_rails(1'b0, 1'b1);
    tick();
    tick();
    check("reset_outputs", dut_pack(), pack(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
    rst = 1'b0;

    foreach (vq[i]) begin
      en  = vq[i].en;
      clr = vq[i].clr;
      set_rails(vq[i].q, vq[i].qn);
      tick();
      check($sformatf("vec%0d", i), dut_pack(), vq[i].exp);
    end
    clr = 1'b0;

    // Twenty clean toggles saturate the 4-bit toggle counter.
    rq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rq = ~rq;
      set_rails(rq, ~rq);
      tick();
      tick();
    end
    repeat (3) tick();
    check("sat_toggle_cnt", 32'(toggle_cnt), 32'd15);
    check("sat_flag", 32'(cnt_sat), 32'd1);
    check("sat_state_low", 32'(state), 32'd1);

    // A 20-cycle high phase saturates the measured high time.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    set_rails(1'b1, 1'b0);
    repeat (20) tick();
    set_rails(1'b0, 1'b1);
    repeat (4) tick();
    check("long_high_time", 32'(high_time), 32'd15);
    check("long_high_tog", 32'(toggle_cnt), 32'd2);
    check("long_high_sat", 32'(cnt_sat), 32'd1);

    // Partial high phase acquired from INIT never updates high_time.
    rst = 1'b1; en = 1'b0;
    set_rails(1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    tick();
    check("partial_init_high", 32'(state), 32'd2);
    check("partial_no_rise", 32'(rise_pulse), 32'd0);
    repeat (6) tick();
    set_rails(1'b0, 1'b1);
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      tick();
      if (fall_pulse === 1'b1) seen = 1;
    end
    check("partial_fall_seen", 32'(seen), 32'd1);
    check("partial_tog", 32'(toggle_cnt), 32'd1);
    check("partial_high_time", 32'(high_time), 32'd0);

    // clr lands on the cycle the rising edge would be detected.
    set_rails(1'b1, 1'b0);
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_edge_bundle", dut_pack(), pack(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
    tick();
    check("clr_reacquire_high", 32'(state), 32'd2);
    check("clr_reacquire_no_rise", 32'(rise_pulse), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_high", dut_pack(), pack(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
    rst = 1'b0;

    // Randomized run against the model.
    rq = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      pflip = (n < 1000) ? 3 : 29;
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 79) == 0);
      en  = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, pflip) == 0) rq = ~rq;
      set_rails(rq, ($urandom_range(0, 14) == 0) ? rq : ~rq);
      tick();
      check($sformatf("rand%0d", n), dut_pack(), model_pack());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
